// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC path: serializer states, default sizes, bit order.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package crc_pkg;

    localparam int CRC_DATA_WIDTH = 8;
    localparam int CRC_GAP_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_e;

    // Bit order on the serial wire; the CRC block and the collector use the same enum.
    typedef enum logic {
        BIT_ORDER_MSB_FIRST = 1'b0,
        BIT_ORDER_LSB_FIRST = 1'b1
    } bit_order_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crc_shift_reg.sv
// Loadable shift register presenting one bit per clock in the selected bit order.
// Latency: loaded word's first bit is on cur_bit the cycle after load.
// Backpressure: none; load/shift are issued by the owning FSM (load wins over shift).
//
// Ports: clk/rst (async active-high), load + load_data (parallel load),
//        shift (advance one bit, zero-fill), cur_bit (bit currently presented).
module crc_shift_reg
    import crc_pkg::*;
#(
    parameter int         WIDTH = CRC_DATA_WIDTH,
    parameter bit_order_e ORDER = BIT_ORDER_LSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             cur_bit
);

    logic [WIDTH-1:0] sr;

    // Zero-fill on shift: once the last bit is shifted out the register is all-zero,
    // so cur_bit naturally reads 0 between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= load_data;
        end else if (shift) begin
            if (ORDER == BIT_ORDER_LSB_FIRST) begin
                sr <= sr >> 1;
            end else begin
                sr <= sr << 1;
            end
        end
    end

    assign cur_bit = (ORDER == BIT_ORDER_LSB_FIRST) ? sr[0] : sr[WIDTH-1];

endmodule

// File: rtl/crc_bit_serializer.sv
// Serializes parallel words one bit per clock toward the serial CRC block, with an idle gap per frame.
// Latency: first bit on DATA (ACTIVE=1) one cycle after the accept edge; words of a frame run back-to-back.
// Backpressure: in_ready only in IDLE or on the final bit of a non-last word; held in_valid is ignored otherwise.
//
// Ports: CLK, RST (async active-high); in_data/in_valid/in_last/in_ready (word handshake);
//        DATA/ACTIVE (registered serial stream); busy (not IDLE);
//        frame_done (pulse in first IDLE cycle after the gap); underrun (pulse when a frame is cut short).
module crc_bit_serializer
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = CRC_DATA_WIDTH,
    parameter int GAP_CYCLES = CRC_GAP_CYCLES,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  DATA,
    output logic                  ACTIVE,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun
);

    localparam int BIT_CNT_W = cnt_width(DATA_WIDTH);
    localparam int GAP_CNT_W = $clog2(GAP_CYCLES + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_CYCLES - 1);
    localparam bit_order_e ORDER = LSB_FIRST ? BIT_ORDER_LSB_FIRST : BIT_ORDER_MSB_FIRST;

    ser_state_e           state;
    ser_state_e           state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 last_flag;
    logic                 accept;
    logic                 shift_en;
    logic                 active_q;
    logic                 frame_done_q;
    logic                 underrun_q;
    logic                 shift_bit;

    assign accept   = in_valid && in_ready;
    // A reload replaces the shift on the final bit, which keeps ACTIVE continuous.
    assign shift_en = (state == SHIFT) && !accept;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if ((bit_cnt == BIT_LAST) && !accept) state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: in_ready is a function of state, bit_cnt and last_flag only
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SHIFT:   in_ready = (bit_cnt == BIT_LAST) && !last_flag;
            default: in_ready = 1'b0;
        endcase
    end

    // Counters, last flag and registered status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            last_flag    <= 1'b0;
            active_q     <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            active_q     <= (state_nxt == SHIFT);
            frame_done_q <= (state == GAP) && (gap_cnt == GAP_LAST);
            // Final bit of a non-last word with nothing to reload: frame is terminated early.
            underrun_q   <= (state == SHIFT) && (bit_cnt == BIT_LAST) && !last_flag && !accept;

            if (accept) begin
                bit_cnt   <= '0;
                last_flag <= in_last;
            end else if (state == SHIFT) begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt   <= '0;
                    last_flag <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (state == GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
            end
        end
    end

    crc_shift_reg #(
        .WIDTH (DATA_WIDTH),
        .ORDER (ORDER)
    ) u_shift_reg (
        .clk       (CLK),
        .rst       (RST),
        .load      (accept),
        .shift     (shift_en),
        .load_data (in_data),
        .cur_bit   (shift_bit)
    );

    assign DATA       = shift_bit;
    assign ACTIVE     = active_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_crc_bit_serializer.sv
// Bench for crc_bit_serializer: table of single-word frames, hand sequences, randomized traffic vs schedule model.
// Latency: n/a.
// Backpressure: n/a.
module tb_crc_bit_serializer;
    import crc_pkg::*;

    localparam int W = CRC_DATA_WIDTH;
    localparam int G = CRC_GAP_CYCLES;

    // One expected output cycle in the reference timeline.
    typedef struct packed {
        logic active;
        logic dat;
        logic ready;
        logic ur;
        logic fd;
        logic last_bit;
        logic frame_last;
    } ent_t;

    // Single-word frame vector: word and the serial bits expected, first-sent bit in the MSB.
    typedef struct packed {
        logic [W-1:0] word;
        logic [W-1:0] exp_ser;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         dout;
    logic         active;
    logic         busy;
    logic         frame_done;
    logic         underrun;

    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;
    logic         m_dout;
    logic         m_active;
    logic         m_busy;
    logic         m_fd;
    logic         m_ur;

    int   checks = 0;
    int   errors = 0;
    ent_t tl[$];

    always #5 clk = ~clk;

    crc_bit_serializer #(.DATA_WIDTH(W), .GAP_CYCLES(G), .LSB_FIRST(1'b1)) dut (
        .CLK(clk), .RST(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .DATA(dout), .ACTIVE(active), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    crc_bit_serializer #(.DATA_WIDTH(W), .GAP_CYCLES(G), .LSB_FIRST(1'b0)) dut_msb (
        .CLK(clk), .RST(rst), .in_data(m_data), .in_valid(m_valid), .in_last(m_last),
        .in_ready(m_ready), .DATA(m_dout), .ACTIVE(m_active), .busy(m_busy),
        .frame_done(m_fd), .underrun(m_ur)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ent_t cur_ent();
        ent_t e;
        if (tl.size() > 0) return tl[0];
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Advance the timeline across one rising edge given the inputs presented for it.
    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic l);
        ent_t c;
        ent_t e;
        c = cur_ent();
        if (tl.size() > 0) void'(tl.pop_front());
        if (v && c.ready) begin
            for (int i = 0; i < W; i++) begin
                e = '0;
                e.active     = 1'b1;
                e.dat        = d[i];
                e.last_bit   = (i == W - 1);
                e.frame_last = l;
                e.ready      = (i == W - 1) && !l;
                tl.push_back(e);
            end
        end else if (c.last_bit) begin
            for (int g = 0; g < G; g++) begin
                e = '0;
                e.ur = (g == 0) && !c.frame_last;
                tl.push_back(e);
            end
            e = '0;
            e.ready = 1'b1;
            e.fd    = 1'b1;
            tl.push_back(e);
        end
    endtask

    task automatic check_model();
        ent_t       c;
        logic [5:0] exp_v;
        logic [5:0] act_v;
        c = cur_ent();
        exp_v = {c.active, c.dat, c.ready, (tl.size() > 0) && !c.fd, c.ur, c.fd};
        act_v = {active, dout, in_ready, busy, underrun, frame_done};
        chk("model {act,dat,rdy,busy,ur,fd}", 32'(act_v), 32'(exp_v));
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        model_edge(v, d, l);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs[8];
        logic [15:0]  ser16;
        logic [W-1:0] ser;
        int           nrdy, rdyk, gaprdy, nur, urk, nfd, fdk, nact;
        logic         all_act;

        vecs[0] = '{8'hA5, 8'b10100101};
        vecs[1] = '{8'h0F, 8'b11110000};
        vecs[2] = '{8'h01, 8'b10000000};
        vecs[3] = '{8'h80, 8'b00000001};
        vecs[4] = '{8'hC6, 8'b01100011};
        vecs[5] = '{8'h12, 8'b01001000};
        vecs[6] = '{8'h00, 8'b00000000};
        vecs[7] = '{8'hFF, 8'b11111111};

        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        m_valid  = 1'b0; m_data  = '0; m_last  = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset {act,dat,rdy,busy,ur,fd}", 32'({active, dout, in_ready, busy, underrun, frame_done}), 32'(6'b001000));
        chk("reset msb {act,dat,rdy,busy,ur,fd}", 32'({m_active, m_dout, m_ready, m_busy, m_ur, m_fd}), 32'(6'b001000));
        rst = 1'b0;
        #1 check_model();

        // Single-word frames from the table
        foreach (vecs[n]) begin
            step(1'b1, vecs[n].word, 1'b1);
            for (int i = 0; i < W; i++) begin
                chk("tbl_bit", 32'({active, dout}), 32'({1'b1, vecs[n].exp_ser[W-1-i]}));
                step(1'b0, '0, 1'b0);
            end
            for (int g = 0; g < G; g++) begin
                chk("tbl_gap {act,fd}", 32'({active, frame_done}), 32'(2'b00));
                step(1'b0, '0, 1'b0);
            end
            chk("tbl_done", 32'(frame_done), 32'(1));
        end

        // Back-to-back 0x3C then 0x81 (last), valid held high
        step(1'b1, 8'h3C, 1'b0);
        nrdy = 0; rdyk = -1; all_act = 1'b1; ser16 = '0;
        for (int k = 0; k < 16; k++) begin
            ser16[15-k] = dout;
            all_act &= active;
            if (in_ready) begin nrdy++; rdyk = k; end
            step(k < 8, 8'h81, 1'b1);
        end
        chk("b2b_bits", 32'(ser16), 32'(16'b0011110010000001));
        chk("b2b_active_contiguous", 32'(all_act), 32'(1));
        chk("b2b_ready_count", 32'(nrdy), 32'(1));
        chk("b2b_ready_cycle", 32'(rdyk), 32'(W - 1));
        idle(G);
        chk("b2b_done", 32'(frame_done), 32'(1));

        // Underrun: non-last word, valid dropped
        step(1'b1, 8'h0F, 1'b0);
        nur = 0; urk = -1; nfd = 0; fdk = -1;
        for (int k = 0; k <= W + G; k++) begin
            if (underrun)   begin nur++; urk = k; end
            if (frame_done) begin nfd++; fdk = k; end
            step(1'b0, '0, 1'b0);
        end
        chk("ur_count", 32'(nur), 32'(1));
        chk("ur_cycle", 32'(urk), 32'(W));
        chk("ur_done_count", 32'(nfd), 32'(1));
        chk("ur_done_cycle", 32'(fdk), 32'(W + G));
        step(1'b1, 8'h55, 1'b1);
        chk("ur_next_active", 32'(active), 32'(1));
        idle(W + G);

        // Backpressure: valid held through the gap
        step(1'b1, 8'h5A, 1'b1);
        nrdy = 0; rdyk = -1; gaprdy = 0;
        for (int k = 0; k <= W + G; k++) begin
            if (in_ready) begin nrdy++; rdyk = k; end
            if (k >= W && k < W + G && in_ready) gaprdy++;
            step(1'b1, 8'h99, 1'b1);
        end
        chk("bp_gap_ready", 32'(gaprdy), 32'(0));
        chk("bp_ready_count", 32'(nrdy), 32'(1));
        chk("bp_ready_cycle", 32'(rdyk), 32'(W + G));
        for (int i = 0; i < W; i++) begin
            ser[W-1-i] = dout;
            step(1'b0, '0, 1'b0);
        end
        chk("bp_word_bits", 32'(ser), 32'(8'b10011001));
        idle(G);

        // Reset during bit 3 of 0xFF
        step(1'b1, 8'hFF, 1'b1);
        idle(3);
        chk("rst_mid_pre_active", 32'(active), 32'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid {act,dat}", 32'({active, dout}), 32'(2'b00));
        tl.delete();
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_after {rdy,busy}", 32'({in_ready, busy}), 32'(2'b10));
        nfd = 0;
        for (int k = 0; k < G + 2; k++) begin
            if (frame_done) nfd++;
            step(1'b0, '0, 1'b0);
        end
        chk("rst_mid_no_done", 32'(nfd), 32'(0));

        // MSB-first build: 0xA0
        m_valid = 1'b1; m_data = 8'hA0; m_last = 1'b1;
        step(1'b0, '0, 1'b0);
        m_valid = 1'b0;
        nact = 0;
        for (int i = 0; i < W; i++) begin
            ser[W-1-i] = m_dout;
            if (m_active) nact++;
            step(1'b0, '0, 1'b0);
        end
        chk("msb_bits", 32'(ser), 32'(8'b10100000));
        chk("msb_active_cycles", 32'(nact), 32'(W));
        idle(G);
        chk("msb_done", 32'(m_fd), 32'(1));

        // Randomized traffic against the timeline model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0);
        end
        idle(W + G + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_bit_serializer.md
Name: crc_bit_serializer

Overview:
- Upstream feeder for the serial CRC block. Accepts parallel bytes over a valid/ready handshake and shifts them out one bit per clock on DATA, with ACTIVE high.
- Holds ACTIVE low for a programmable gap after each frame's last byte so the CRC block can finish and emit its result.
- Supports multi-byte frames streamed back-to-back with no bubble between bytes.

Parameters:
- DATA_WIDTH, 8, width of the parallel input word (bits per word shifted).
- GAP_CYCLES, 8, idle cycles with ACTIVE=0 after a frame ends (must be >=1).
- LSB_FIRST, 1, 1 = bit 0 sent first, 0 = bit DATA_WIDTH-1 sent first.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous reset, active-high.
- in_data  input  DATA_WIDTH  parallel word to serialize.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  word is final word of frame.
- in_ready  output  1  serializer can accept a word this cycle.
- DATA  output  1  serial bit to CRC block.
- ACTIVE  output  1  DATA carries a valid frame bit.
- busy  output  1  state != IDLE.
- frame_done  output  1  one-cycle pulse when the gap completes.
- underrun  output  1  one-cycle pulse when a frame is cut short by missing input.

Behaviour:
- Reset (RST=1, async): state=IDLE; DATA=0, ACTIVE=0, frame_done=0, underrun=0; shift register, bit counter, gap counter and last flag = 0. in_ready=1 once in IDLE.
- DATA, ACTIVE, frame_done and underrun are registered. in_ready is combinational from state, bit counter and last flag only; it never depends on in_valid.
- Accept rule: a word is taken at a rising edge where in_valid & in_ready. in_data and in_last are captured at that edge.
- IDLE:
  - in_ready=1, ACTIVE=0.
  - On accept: load shift register, bit_cnt=0, last_flag=in_last, go to SHIFT.
  - The first bit appears on DATA with ACTIVE=1 in the cycle after the accept edge (latency 1).
- SHIFT:
  - ACTIVE=1; DATA = current bit (LSB or MSB per LSB_FIRST); bit_cnt increments each cycle.
  - in_ready=1 only when bit_cnt==DATA_WIDTH-1 and last_flag==0. Otherwise in_ready=0.
  - At bit_cnt==DATA_WIDTH-1:
    - If a word is accepted: reload, stay in SHIFT. ACTIVE remains continuously 1 (no bubble).
    - If last_flag==1: go to GAP.
    - If last_flag==0 and no word is accepted: underrun pulse next cycle, go to GAP (the frame is terminated).
- GAP:
  - ACTIVE=0, DATA=0, in_ready=0; gap_cnt counts 0..GAP_CYCLES-1.
  - On the final count, go to IDLE and pulse frame_done. frame_done is high in the first IDLE cycle.
- Frame timing: a frame of N words gives N*DATA_WIDTH consecutive ACTIVE=1 cycles, then exactly GAP_CYCLES ACTIVE=0 cycles before the next accept is possible.
- in_valid held high while in_ready=0 is ignored; no word is lost and no word is duplicated.
- Reset mid-frame: all state clears immediately, ACTIVE drops asynchronously, and the partial word is discarded.
- Counter widths: bit_cnt = clog2(DATA_WIDTH); gap_cnt = clog2(GAP_CYCLES+1). No wrap-around except by reload.

Decomposition:
- Shared package crc_pkg holds:
  - state encoding (IDLE, SHIFT, GAP);
  - default CRC_DATA_WIDTH=8 and CRC_GAP_CYCLES=8;
  - the bit-order enum, shared with the CRC block and the downstream CRC collector.
- One natural sub-module: crc_shift_reg. It is a loadable shift register with LSB/MSB select and exposes the current bit. The FSM and counters stay in the top module.

Test Plan:
- Single word 0xA5, in_last=1, LSB_FIRST=1 -> DATA = 1,0,1,0,0,1,0,1 over 8 consecutive ACTIVE=1 cycles starting 1 cycle after accept. Then ACTIVE=0 for 8 cycles, and frame_done pulses once in the cycle after the gap ends.
- Back-to-back frame 0x3C then 0x81 (last on 0x81), in_valid held high -> in_ready=1 only on bit 7 of 0x3C. ACTIVE=1 for 16 contiguous cycles with DATA = 0,0,1,1,1,1,0,0,1,0,0,0,0,0,0,1.
- Underrun: word 0x0F with in_last=0, in_valid dropped after accept -> 8 ACTIVE cycles, underrun pulses once, 8-cycle gap, then frame_done. The next word is accepted normally.
- Backpressure: in_valid=1 throughout the GAP -> in_ready=0 for all 8 gap cycles. The next word is accepted in the first IDLE cycle, exactly once.
- Reset mid-shift: assert RST during bit 3 of 0xFF -> ACTIVE=0 and DATA=0 immediately. After release, in_ready=1 with no residual bits and no frame_done.
- LSB_FIRST=0 build, word 0xA0, last -> DATA = 1,0,1,0,0,0,0,0.
